// File: rtl/load_return_align_if.sv
// Load request / bus response / writeback result handshake bundle for load_return_align.
interface load_return_align_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_addr;
  logic [1:0]  req_msize;
  logic        req_signed;
  logic [4:0]  req_dst;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_dst;

  modport master (
    output req_valid, req_addr, req_msize, req_signed, req_dst,
    output resp_valid, resp_data, out_ready,
    input  req_ready, resp_ready, out_valid, out_data, out_dst
  );

  modport slave (
    input  req_valid, req_addr, req_msize, req_signed, req_dst,
    input  resp_valid, resp_data, out_ready,
    output req_ready, resp_ready, out_valid, out_data, out_dst
  );
endinterface

// File: rtl/load_return_align.sv
// Tracks outstanding loads in order, pairs each returning doubleword with its request,
// extracts and extends the addressed field, and registers it towards writeback.
module load_return_align #(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  load_return_align_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] kill;
  logic [2:0]       addr_q  [DEPTH];
  msize_t           msize_q [DEPTH];
  logic             sgn_q   [DEPTH];
  logic [4:0]       dst_q   [DEPTH];

  logic        enq, deq, head_kill;
  logic [63:0] ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  assign head_kill      = kill[rd_ptr];
  assign bus.req_ready  = (count != CW'(DEPTH));
  assign bus.resp_ready = (count != '0) & (head_kill | ~bus.out_valid | bus.out_ready);
  assign enq            = bus.req_valid & bus.req_ready;
  assign deq            = bus.resp_valid & bus.resp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      kill   <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq & ~deq)      count <= count + 1'b1;
      else if (~enq & deq) count <= count - 1'b1;
      // Marking every slot is safe: free slots get their kill bit rewritten on enqueue.
      if (flush)    kill         <= '1;
      else if (enq) kill[wr_ptr] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr]  <= bus.req_addr;
      msize_q[wr_ptr] <= msize_t'(bus.req_msize);
      sgn_q[wr_ptr]   <= bus.req_signed;
      dst_q[wr_ptr]   <= bus.req_dst;
    end
  end

  always_comb begin
    byte_v = bus.resp_data[{addr_q[rd_ptr], 3'b000} +: 8];
    half_v = bus.resp_data[{addr_q[rd_ptr][2:1], 4'b0000} +: 16];
    word_v = bus.resp_data[{addr_q[rd_ptr][2], 5'b00000} +: 32];
    ext    = bus.resp_data;
    unique case (msize_q[rd_ptr])
      MSIZE1:  ext = {{56{sgn_q[rd_ptr] & byte_v[7]}}, byte_v};
      MSIZE2:  ext = {{48{sgn_q[rd_ptr] & half_v[15]}}, half_v};
      MSIZE4:  ext = {{32{sgn_q[rd_ptr] & word_v[31]}}, word_v};
      default: ext = bus.resp_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_dst   <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (deq & ~head_kill) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= ext;
      bus.out_dst   <= dst_q[rd_ptr];
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_load_return_align.sv
// Directed and random checks of load_return_align against a queue-based load model.
module tb_load_return_align;
  localparam int unsigned DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  load_return_align_if bus ();

  load_return_align #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] addr;
    logic [1:0] msize;
    logic       sgn;
    logic [4:0] dst;
    logic       kill;
  } ent_t;

  ent_t        q[$];
  logic        m_ov   = 1'b0;
  logic [63:0] m_data = '0;
  logic [4:0]  m_dst  = '0;
  int          n_cmp  = 0;
  int          n_bad  = 0;

  function automatic logic [63:0] extract(logic [2:0] a, logic [1:0] sz, logic s, logic [63:0] d);
    int unsigned nb, off;
    logic [63:0] v, mask;
    nb  = 1 << sz;
    off = (a / nb) * nb;
    v   = d >> (8 * off);
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = v & mask;
      if (s && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic m_req_ready();
    return q.size() != DEPTH;
  endfunction

  function automatic logic m_resp_ready();
    return q.size() != 0 && (q[0].kill || !m_ov || bus.out_ready);
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: advances on each clock edge from the inputs seen at that edge.
  logic m_rr, m_rs, m_enq, m_deq;
  ent_t m_e;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_ov = 1'b0; m_data = '0; m_dst = '0;
    end else begin
      m_rr  = m_req_ready();
      m_rs  = m_resp_ready();
      m_enq = bus.req_valid && m_rr;
      m_deq = bus.resp_valid && m_rs;
      m_e   = '{addr: 3'd0, msize: 2'd0, sgn: 1'b0, dst: 5'd0, kill: 1'b1};
      if (m_deq) m_e = q.pop_front();
      if (flush) m_ov = 1'b0;
      else if (m_deq && !m_e.kill) begin
        m_ov   = 1'b1;
        m_data = extract(m_e.addr, m_e.msize, m_e.sgn, bus.resp_data);
        m_dst  = m_e.dst;
      end else if (m_ov && bus.out_ready) m_ov = 1'b0;
      if (flush) foreach (q[i]) q[i].kill = 1'b1;
      if (m_enq) q.push_back('{addr: bus.req_addr, msize: bus.req_msize, sgn: bus.req_signed,
                               dst: bus.req_dst, kill: flush});
    end
  end

  always @(negedge clk) begin
    chk("req_ready", 64'(bus.req_ready), 64'(m_req_ready()));
    chk("resp_ready", 64'(bus.resp_ready), 64'(m_resp_ready()));
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_data", bus.out_data, m_data);
      chk("out_dst", 64'(bus.out_dst), 64'(m_dst));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0; bus.resp_valid = 1'b0; bus.out_ready = 1'b1; flush = 1'b0;
  endtask

  task automatic set_req(logic [2:0] a, logic [1:0] sz, logic s, logic [4:0] d);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_msize = sz; bus.req_signed = s; bus.req_dst = d;
  endtask

  task automatic set_resp(logic [63:0] d);
    bus.resp_valid = 1'b1; bus.resp_data = d;
  endtask

  initial begin
    bus.req_addr = '0; bus.req_msize = '0; bus.req_signed = 1'b0; bus.req_dst = '0;
    bus.resp_data = '0;
    idle();
    tick(); tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_dst", 64'(bus.out_dst), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_ready", 64'(bus.resp_ready), 64'd0);
    reset = 1'b0;
    tick();

    // LB signed, byte 3
    set_req(3'd3, 2'd0, 1'b1, 5'd9); tick(); idle();
    set_resp(64'h0000_0000_8000_0000); tick(); idle();
    chk("lb_valid", 64'(bus.out_valid), 64'd1);
    chk("lb_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_dst", 64'(bus.out_dst), 64'd9);
    tick();

    // LHU addr 6 then LW signed addr 4, back-to-back responses
    set_req(3'd6, 2'd1, 1'b0, 5'd10); tick();
    set_req(3'd4, 2'd2, 1'b1, 5'd11); tick(); idle();
    set_resp(64'hBEEF_0000_0000_0000); tick();
    chk("lhu_data", bus.out_data, 64'h0000_0000_0000_BEEF);
    set_resp(64'h8000_0001_1234_5678); tick(); idle();
    chk("lw_data", bus.out_data, 64'hFFFF_FFFF_8000_0001);
    chk("lw_dst", 64'(bus.out_dst), 64'd11);
    tick();

    // Fill to DEPTH, then drain across pointer wrap
    for (int i = 1; i <= 4; i++) begin set_req(3'd0, 2'd3, 1'b0, 5'(i)); tick(); end
    idle();
    chk("full_req_ready", 64'(bus.req_ready), 64'd0);
    set_resp(64'd1); tick();
    chk("after1_req_ready", 64'(bus.req_ready), 64'd1);
    chk("wrap_dst1", 64'(bus.out_dst), 64'd1);
    for (int i = 2; i <= 6; i++) begin
      if (i <= 3) set_req(3'd0, 2'd3, 1'b0, 5'(i + 3));
      else bus.req_valid = 1'b0;
      set_resp(64'(i)); tick();
      chk("wrap_dst", 64'(bus.out_dst), 64'(i));
      chk("wrap_data", bus.out_data, 64'(i));
    end
    idle(); tick();

    // Backpressure from writeback
    set_req(3'd0, 2'd3, 1'b0, 5'd12); tick();
    set_req(3'd0, 2'd3, 1'b0, 5'd13); tick(); idle();
    bus.out_ready = 1'b0;
    set_resp(64'hAAAA_0000_0000_0001); tick();
    set_resp(64'hBBBB_0000_0000_0002);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_ready", 64'(bus.resp_ready), 64'd0);
      chk("bp_hold_data", bus.out_data, 64'hAAAA_0000_0000_0001);
      chk("bp_hold_dst", 64'(bus.out_dst), 64'd12);
      tick();
    end
    bus.out_ready = 1'b1; tick(); idle();
    chk("bp_next_data", bus.out_data, 64'hBBBB_0000_0000_0002);
    chk("bp_next_dst", 64'(bus.out_dst), 64'd13);
    tick();

    // Flush with two outstanding, then a fresh load
    set_req(3'd0, 2'd3, 1'b0, 5'd14); tick();
    set_req(3'd0, 2'd3, 1'b0, 5'd15); tick(); idle();
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_resp(64'hDEAD); 
      chk("flush_resp_ready", 64'(bus.resp_ready), 64'd1);
      tick();
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    end
    idle();
    set_req(3'd0, 2'd3, 1'b0, 5'd7); tick(); idle();
    set_resp(64'h1234_5678_9ABC_DEF0); tick(); idle();
    chk("post_flush_valid", 64'(bus.out_valid), 64'd1);
    chk("post_flush_dst", 64'(bus.out_dst), 64'd7);
    tick();

    // Async reset mid-burst
    for (int i = 0; i < 4; i++) begin set_req(3'd0, 2'd3, 1'b0, 5'(20 + i)); tick(); end
    idle();
    bus.out_ready = 1'b0;
    set_resp(64'h55); tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("arst_resp_ready", 64'(bus.resp_ready), 64'd0);
    chk("arst_out_dst", 64'(bus.out_dst), 64'd0);
    tick(); reset = 1'b0;
    chk("arst_stall", 64'(bus.resp_ready), 64'd0);
    tick();
    chk("arst_no_accept", 64'(bus.out_valid), 64'd0);
    idle(); tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid  = 1'($urandom_range(0, 1));
      bus.req_addr   = 3'($urandom);
      bus.req_msize  = 2'($urandom);
      bus.req_signed = 1'($urandom);
      bus.req_dst    = 5'($urandom);
      bus.resp_valid = (q.size() != 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      bus.resp_data  = {$urandom, $urandom};
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
